trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Initiator side of the core's trap interface to csrUnit. Collects synchronous exception flags and the timer-interrupt flag for the instruction at the commit boundary, picks one by fixed priority, and issues the registered excRequest/cause/trapInfo/pc handshake. It then redirects fetch to mtvec, and on MRET redirects fetch to mepc. It also pulses the mstatus stacking strobes consumed by csrUnit.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMER_INT_EN, 1, when 0 mtime_exc_i is ignored.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid_i  in  1  instruction at commit boundary this cycle
pc_i  in  32  PC of that instruction
instr_i  in  32  raw instruction bits
exc_iam_i  in  1  instruction address misaligned
exc_ill_i  in  1  illegal instruction
exc_ebreak_i  in  1  EBREAK
exc_ecall_i  in  1  ECALL from M-mode
exc_lam_i  in  1  load address misaligned
exc_sam_i  in  1  store address misaligned
bad_addr_i  in  32  faulting target or data address
mret_i  in  1  MRET at commit
mtime_exc_i  in  1  timer interrupt pending and enabled (from csrUnit)
mtvec_i  in  32  trap vector (from csrUnit)
mepc_i  in  32  saved PC (from csrUnit)
exc_request_o  out  1  trap request to csrUnit
exc_cause_o  out  32  cause code
trap_info_o  out  32  mtval value
exc_pc_o  out  32  PC to save into mepc
trap_entry_o  out  1  pulse: MPIE<=MIE, MIE<=0
trap_return_o  out  1  pulse: MIE<=MPIE, MPIE<=1
stall_o  out  1  block commit and PC update
flush_o  out  1  kill in-flight instruction
redirect_valid_o  out  1  load PC from redirect_pc_o
redirect_pc_o  out  32  redirect target

Behaviour:
- Reset is synchronous and active-high on clk. On reset, state goes to IDLE and every output is 0, including the 32-bit outputs. Reset asserted in any state aborts the sequence with no redirect.
- A trap is detected when instr_valid_i is 1 and any exc_* flag is 1, or when (TIMER_INT_EN and mtime_exc_i) is 1. Flags sampled while instr_valid_i is 0 are ignored.
- Priority, highest first, with cause and trap_info:
  - timer: cause 0x8000_0007, info 0
  - iam: cause 0, info bad_addr_i
  - ill: cause 2, info instr_i
  - ebreak: cause 3, info pc_i
  - ecall: cause 11, info 0
  - lam: cause 4, info bad_addr_i
  - sam: cause 6, info bad_addr_i
- A timer trap with instr_valid_i=0 uses the last committed pc_i, latched on every valid commit.
- stall_o = trap_detect in IDLE (combinational) | (state != IDLE). flush_o follows the same equation.
- FSM states: IDLE, REQ, VEC, RET.
  - IDLE, trap detected: register cause, info and pc; go to REQ.
  - IDLE, mret_i & instr_valid_i with no trap: go to RET.
  - IDLE, trap and mret_i in the same cycle: trap wins; exc_pc_o is the MRET's PC.
  - REQ: exc_request_o=1 and trap_entry_o=1 for exactly one cycle, with cause, info and pc valid; go to VEC.
  - VEC: redirect_valid_o=1, redirect_pc_o={mtvec_i[31:2],2'b00} sampled this cycle; go to IDLE.
  - RET: redirect_valid_o=1, redirect_pc_o={mepc_i[31:2],2'b00}, trap_return_o=1; go to IDLE.
- Latency:
  - Trap detected in cycle N: request in N+1, redirect in N+2.
  - MRET committed in cycle N: redirect in N+1.
- exc_cause_o, trap_info_o and exc_pc_o hold their values until the next capture. exc_request_o is a single-cycle pulse.
- New triggers arriving in REQ, VEC or RET are ignored. Upstream holds them because stall_o is high and re-presents them in IDLE.
- No back-to-back requests: at least 2 cycles separate consecutive exc_request_o pulses.

Decomposition:
- riscV_unrn_pkg gains:
  - trap_state_t enum {IDLE, REQ, VEC, RET}
  - exception cause constants EXC_IAM=0, EXC_ILL=2, EXC_BRK=3, EXC_LAM=4, EXC_SAM=6, EXC_ECALL_M=11
  - the existing M_TIMER_INT is reused
- One sub-module: trap_priority_encoder, purely combinational. It maps the flags to (hit, cause, info_sel), and the sequencer instantiates it once.

Test Plan:
- Illegal instruction: instr_valid_i=1, exc_ill_i=1, pc_i=0x100, instr_i=0xFFFF_FFFF, mtvec_i=0x200 → next cycle exc_request_o=1, cause=2, trap_info_o=0xFFFF_FFFF, exc_pc_o=0x100; following cycle redirect_valid_o=1, redirect_pc_o=0x200.
- Priority: ecall+lam both set, bad_addr_i=0x1003 → cause=11, info=0. Then lam alone → cause=4, info=0x1003.
- Timer vs MRET: mtime_exc_i=1 with mret_i=1 at pc_i=0x40 → cause=0x8000_0007, exc_pc_o=0x40, trap_return_o stays 0.
- MRET: mret_i=1, mepc_i=0x0000_0123 → next cycle redirect_pc_o=0x120, trap_return_o=1, exc_request_o=0.
- Reset in VEC: rst=1 during VEC → next cycle all outputs 0, state IDLE, no redirect.
- Retrigger during stall: exc_ecall_i held for 3 cycles → exactly one request, then a second request 3 cycles after the first if the flag is still held in IDLE.

Source files
------------

// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the core's trap path.
// Contents: the trap sequencer state type, the mtval source selector
// used between the priority encoder and the sequencer, and the
// machine-mode cause codes.
package riscV_unrn_pkg;

   // Machine timer interrupt: interrupt bit set, code 7.
   localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;

   // Synchronous exception cause codes.
   localparam logic [31:0] EXC_IAM     = 32'd0;
   localparam logic [31:0] EXC_ILL     = 32'd2;
   localparam logic [31:0] EXC_BRK     = 32'd3;
   localparam logic [31:0] EXC_LAM     = 32'd4;
   localparam logic [31:0] EXC_SAM     = 32'd6;
   localparam logic [31:0] EXC_ECALL_M = 32'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      VEC  = 2'd2,
      RET  = 2'd3
   } trap_state_t;

   // Which value becomes mtval for the selected trap.
   typedef enum logic [1:0] {
      INFO_ZERO  = 2'd0,
      INFO_ADDR  = 2'd1,
      INFO_INSTR = 2'd2,
      INFO_PC    = 2'd3
   } info_sel_t;

endpackage

// File: rtl/trap_priority_encoder.sv
// Fixed-priority selection among the pending trap sources.
// Inputs : timer, iam, ill, ebreak, ecall, lam, sam - already qualified
//          trap flags (timer enable and instruction-valid applied upstream).
// Outputs: hit      - at least one source is pending
//          cause    - cause code of the winning source
//          info_sel - which value the sequencer should report as mtval
module trap_priority_encoder
   import riscV_unrn_pkg::*;
(
   input  logic        timer,
   input  logic        iam,
   input  logic        ill,
   input  logic        ebreak,
   input  logic        ecall,
   input  logic        lam,
   input  logic        sam,
   output logic        hit,
   output logic [31:0] cause,
   output info_sel_t   info_sel
);

   always_comb begin
      hit      = 1'b1;
      cause    = 32'd0;
      info_sel = INFO_ZERO;
      if (timer) begin
         cause = M_TIMER_INT;
      end else if (iam) begin
         cause    = EXC_IAM;
         info_sel = INFO_ADDR;
      end else if (ill) begin
         cause    = EXC_ILL;
         info_sel = INFO_INSTR;
      end else if (ebreak) begin
         cause    = EXC_BRK;
         info_sel = INFO_PC;
      end else if (ecall) begin
         cause = EXC_ECALL_M;
      end else if (lam) begin
         cause    = EXC_LAM;
         info_sel = INFO_ADDR;
      end else if (sam) begin
         cause    = EXC_SAM;
         info_sel = INFO_ADDR;
      end else begin
         hit = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Initiator side of the trap interface to csrUnit.
// Picks one trap per commit boundary by fixed priority, issues a one-cycle
// exc_request_o with registered cause/mtval/pc, then redirects fetch to
// mtvec. An MRET at commit redirects fetch to mepc. trap_entry_o and
// trap_return_o are the mstatus stacking strobes for csrUnit.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid_i, pc_i, instr_i  committing instruction
//   exc_*_i, bad_addr_i           synchronous exception flags and address
//   mret_i, mtime_exc_i           MRET at commit, timer interrupt pending
//   mtvec_i, mepc_i               trap vector and saved PC from csrUnit
//   exc_request_o, exc_cause_o, trap_info_o, exc_pc_o   trap handshake
//   trap_entry_o, trap_return_o   mstatus stacking pulses
//   stall_o, flush_o              hold commit / kill in-flight instruction
//   redirect_valid_o, redirect_pc_o  fetch redirect
module trap_sequencer
   import riscV_unrn_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter bit TIMER_INT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic            exc_iam_i,
   input  logic            exc_ill_i,
   input  logic            exc_ebreak_i,
   input  logic            exc_ecall_i,
   input  logic            exc_lam_i,
   input  logic            exc_sam_i,
   input  logic [XLEN-1:0] bad_addr_i,
   input  logic            mret_i,
   input  logic            mtime_exc_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            exc_request_o,
   output logic [XLEN-1:0] exc_cause_o,
   output logic [XLEN-1:0] trap_info_o,
   output logic [XLEN-1:0] exc_pc_o,
   output logic            trap_entry_o,
   output logic            trap_return_o,
   output logic            stall_o,
   output logic            flush_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   // Redirect targets are always word aligned.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   trap_state_t     state_reg, state_next;
   logic [XLEN-1:0] cause_reg, info_reg, pc_reg, last_pc_reg;

   logic            timer_hit;
   logic            enc_hit;
   logic [31:0]     enc_cause;
   info_sel_t       enc_sel;
   logic [XLEN-1:0] info_next;
   logic [XLEN-1:0] trap_pc;
   logic            capture;

   // The timer is independent of commit; every other flag only counts
   // for an instruction actually at the commit boundary.
   assign timer_hit = TIMER_INT_EN & mtime_exc_i;

   trap_priority_encoder u_prio (
      .timer    (timer_hit),
      .iam      (instr_valid_i & exc_iam_i),
      .ill      (instr_valid_i & exc_ill_i),
      .ebreak   (instr_valid_i & exc_ebreak_i),
      .ecall    (instr_valid_i & exc_ecall_i),
      .lam      (instr_valid_i & exc_lam_i),
      .sam      (instr_valid_i & exc_sam_i),
      .hit      (enc_hit),
      .cause    (enc_cause),
      .info_sel (enc_sel)
   );

   always_comb begin
      info_next = '0;
      case (enc_sel)
         INFO_ADDR:  info_next = bad_addr_i;
         INFO_INSTR: info_next = instr_i;
         INFO_PC:    info_next = pc_i;
         default:    info_next = '0;
      endcase
   end

   // A timer trap between commits reports the last committed PC.
   assign trap_pc = instr_valid_i ? pc_i : last_pc_reg;

   always_comb begin
      state_next       = state_reg;
      capture          = 1'b0;
      exc_request_o    = 1'b0;
      trap_entry_o     = 1'b0;
      trap_return_o    = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state_reg)
         IDLE: begin
            // A trap outranks an MRET in the same cycle.
            if (enc_hit) begin
               capture    = 1'b1;
               state_next = REQ;
            end else if (mret_i && instr_valid_i) begin
               state_next = RET;
            end
         end
         REQ: begin
            exc_request_o = 1'b1;
            trap_entry_o  = 1'b1;
            state_next    = VEC;
         end
         VEC: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = mtvec_i & ALIGN_MASK;
            state_next       = IDLE;
         end
         RET: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = mepc_i & ALIGN_MASK;
            trap_return_o    = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stall immediately on detection so upstream holds the instruction,
   // and keep stalling until the sequence returns to IDLE.
   assign stall_o = (state_reg == IDLE) ? enc_hit : 1'b1;
   assign flush_o = stall_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cause_reg   <= '0;
         info_reg    <= '0;
         pc_reg      <= '0;
         last_pc_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            cause_reg <= XLEN'(enc_cause);
            info_reg  <= info_next;
            pc_reg    <= trap_pc;
         end
         if (instr_valid_i) begin
            last_pc_reg <= pc_i;
         end
      end
   end

   assign exc_cause_o = cause_reg;
   assign trap_info_o = info_reg;
   assign exc_pc_o    = pc_reg;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by
// randomized traffic, all checked every cycle against a schedule-based
// reference model (accepted trap -> request next cycle, redirect the cycle
// after; accepted MRET -> redirect next cycle).
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid_i;
   logic [31:0] pc_i, instr_i, bad_addr_i, mtvec_i, mepc_i;
   logic        exc_iam_i, exc_ill_i, exc_ebreak_i, exc_ecall_i;
   logic        exc_lam_i, exc_sam_i, mret_i, mtime_exc_i;
   logic        exc_request_o, trap_entry_o, trap_return_o;
   logic        stall_o, flush_o, redirect_valid_o;
   logic [31:0] exc_cause_o, trap_info_o, exc_pc_o, redirect_pc_o;

   trap_sequencer #(.XLEN(32), .TIMER_INT_EN(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid_i    (instr_valid_i),
      .pc_i             (pc_i),
      .instr_i          (instr_i),
      .exc_iam_i        (exc_iam_i),
      .exc_ill_i        (exc_ill_i),
      .exc_ebreak_i     (exc_ebreak_i),
      .exc_ecall_i      (exc_ecall_i),
      .exc_lam_i        (exc_lam_i),
      .exc_sam_i        (exc_sam_i),
      .bad_addr_i       (bad_addr_i),
      .mret_i           (mret_i),
      .mtime_exc_i      (mtime_exc_i),
      .mtvec_i          (mtvec_i),
      .mepc_i           (mepc_i),
      .exc_request_o    (exc_request_o),
      .exc_cause_o      (exc_cause_o),
      .trap_info_o      (trap_info_o),
      .exc_pc_o         (exc_pc_o),
      .trap_entry_o     (trap_entry_o),
      .trap_return_o    (trap_return_o),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: cycle numbers at which events are due.
   int          free_at = 0;
   int          req_at  = -1;
   int          vec_at  = -1;
   int          ret_at  = -1;
   int          cap_at  = -1;
   logic [31:0] held_cause = 0, held_info = 0, held_pc = 0;
   logic [31:0] pend_cause = 0, pend_info = 0, pend_pc = 0;
   logic [31:0] last_pc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Trap selection straight from the priority table.
   task automatic model_trap(output bit hit, output logic [31:0] cause, output logic [31:0] info);
      hit = 1'b1; cause = 0; info = 0;
      if (mtime_exc_i)                        begin cause = 32'h8000_0007; info = 0;          end
      else if (instr_valid_i && exc_iam_i)    begin cause = 0;             info = bad_addr_i; end
      else if (instr_valid_i && exc_ill_i)    begin cause = 2;             info = instr_i;    end
      else if (instr_valid_i && exc_ebreak_i) begin cause = 3;             info = pc_i;       end
      else if (instr_valid_i && exc_ecall_i)  begin cause = 11;            info = 0;          end
      else if (instr_valid_i && exc_lam_i)    begin cause = 4;             info = bad_addr_i; end
      else if (instr_valid_i && exc_sam_i)    begin cause = 6;             info = bad_addr_i; end
      else hit = 1'b0;
   endtask

   task automatic clear_inputs();
      instr_valid_i = 0; exc_iam_i = 0; exc_ill_i = 0; exc_ebreak_i = 0;
      exc_ecall_i = 0; exc_lam_i = 0; exc_sam_i = 0; mret_i = 0; mtime_exc_i = 0;
   endtask

   // One clock cycle: inputs are already applied; check, advance model, clock.
   task automatic step(input bit do_check);
      bit          hit, busy;
      logic [31:0] c, inf;
      logic [31:0] exp_rpc;
      #2;
      if (cap_at == cyc) begin
         held_cause = pend_cause; held_info = pend_info; held_pc = pend_pc;
      end
      busy = (cyc < free_at);
      model_trap(hit, c, inf);
      exp_rpc = (vec_at == cyc) ? {mtvec_i[31:2], 2'b00} :
                (ret_at == cyc) ? {mepc_i[31:2], 2'b00} : 32'd0;
      if (do_check) begin
         check("req",       32'(exc_request_o),    32'(req_at == cyc));
         check("entry",     32'(trap_entry_o),     32'(req_at == cyc));
         check("return",    32'(trap_return_o),    32'(ret_at == cyc));
         check("redir_v",   32'(redirect_valid_o), 32'(vec_at == cyc || ret_at == cyc));
         check("redir_pc",  redirect_pc_o,         exp_rpc);
         check("stall",     32'(stall_o),          32'(busy || hit));
         check("flush",     32'(flush_o),          32'(busy || hit));
         check("cause",     exc_cause_o,           held_cause);
         check("info",      trap_info_o,           held_info);
         check("exc_pc",    exc_pc_o,              held_pc);
         if (req_at == cyc)
            $display("cycle %0d trap request cause=%h info=%h pc=%h", cyc, exc_cause_o, trap_info_o, exc_pc_o);
         if (ret_at == cyc)
            $display("cycle %0d mret redirect pc=%h", cyc, redirect_pc_o);
      end
      if (rst) begin
         free_at = cyc + 1; req_at = -1; vec_at = -1; ret_at = -1;
         pend_cause = 0; pend_info = 0; pend_pc = 0; cap_at = cyc + 1;
         last_pc = 0;
      end else begin
         if (!busy) begin
            if (hit) begin
               pend_cause = c; pend_info = inf;
               pend_pc = instr_valid_i ? pc_i : last_pc;
               cap_at = cyc + 1; req_at = cyc + 1; vec_at = cyc + 2; free_at = cyc + 3;
            end else if (mret_i && instr_valid_i) begin
               ret_at = cyc + 1; free_at = cyc + 2;
            end
         end
         if (instr_valid_i) last_pc = pc_i;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      clear_inputs();
      rst = 1; pc_i = 0; instr_i = 0; bad_addr_i = 0; mtvec_i = 0; mepc_i = 0;
      @(posedge clk); #1;
      step(0);
      step(1);
      rst = 0;
      step(1);

      // Illegal instruction
      instr_valid_i = 1; exc_ill_i = 1; pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; mtvec_i = 32'h200;
      step(1);
      clear_inputs();
      repeat (3) step(1);

      // ecall beats lam, then lam alone
      instr_valid_i = 1; exc_ecall_i = 1; exc_lam_i = 1; bad_addr_i = 32'h1003; pc_i = 32'h104;
      step(1);
      clear_inputs();
      repeat (3) step(1);
      instr_valid_i = 1; exc_lam_i = 1; bad_addr_i = 32'h1003; pc_i = 32'h108;
      step(1);
      clear_inputs();
      repeat (3) step(1);

      // Timer together with MRET: trap wins
      instr_valid_i = 1; mtime_exc_i = 1; mret_i = 1; pc_i = 32'h40;
      step(1);
      clear_inputs();
      repeat (3) step(1);

      // Plain MRET
      instr_valid_i = 1; mret_i = 1; mepc_i = 32'h0000_0123; pc_i = 32'h44;
      step(1);
      clear_inputs();
      repeat (2) step(1);

      // Timer between commits reports the last committed PC
      mtime_exc_i = 1;
      step(1);
      clear_inputs();
      repeat (3) step(1);

      // Reset while in VEC
      instr_valid_i = 1; exc_ecall_i = 1; pc_i = 32'h80; mtvec_i = 32'h304;
      step(1);
      clear_inputs();
      step(1);
      rst = 1;
      step(1);
      rst = 0;
      repeat (3) step(1);

      // ecall held across the stall window
      instr_valid_i = 1; exc_ecall_i = 1; pc_i = 32'h90;
      repeat (6) step(1);
      clear_inputs();
      repeat (3) step(1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(99) == 0);
         instr_valid_i = ($urandom_range(3) != 0);
         exc_iam_i     = ($urandom_range(11) == 0);
         exc_ill_i     = ($urandom_range(11) == 0);
         exc_ebreak_i  = ($urandom_range(11) == 0);
         exc_ecall_i   = ($urandom_range(11) == 0);
         exc_lam_i     = ($urandom_range(11) == 0);
         exc_sam_i     = ($urandom_range(11) == 0);
         mret_i        = ($urandom_range(5) == 0);
         mtime_exc_i   = ($urandom_range(15) == 0);
         pc_i       = $urandom; instr_i = $urandom; bad_addr_i = $urandom;
         mtvec_i    = $urandom; mepc_i  = $urandom;
         step(1);
      end
      rst = 0;
      clear_inputs();
      repeat (4) step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
